// File: rtl/song_ctrl.sv
// song_ctrl: session controller for the LED-matrix song player.
// Latches the song choice, sequences ARM/PLAY/PAUSE/DONE/ABORT, runs the
// play watchdog and DONE hold timer, and counts completed songs.
// All outputs are registered and decoded from the next state.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no song; btn_sel cycles selection, btn_start arms
// ARM   | one cycle loader clear, watchdog loaded with 0
// PLAY  | song driven, watchdog counting active cycles
// PAUSE | song held, loader frozen via hold, watchdog frozen
// DONE  | done asserted for DONE_HOLD cycles, buttons ignored
// ABORT | one cycle loader clear, then back to IDLE
module song_ctrl #(
    parameter logic [31:0] TIMEOUT   = 32'd20_000_000,
    parameter logic [31:0] DONE_HOLD = 32'd50_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_sel,
    input  logic       btn_start,
    input  logic       btn_pause,
    input  logic       btn_stop,
    input  logic       finish,
    output logic [1:0] song,
    output logic [1:0] sel_song,
    output logic       loader_rst,
    output logic       hold,
    output logic       playing,
    output logic       done,
    output logic       error,
    output logic [7:0] play_cnt
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ARM   = 3'd1,
        S_PLAY  = 3'd2,
        S_PAUSE = 3'd3,
        S_DONE  = 3'd4,
        S_ABORT = 3'd5
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] wd_q, wd_d;
    logic [31:0] hc_q, hc_d;
    logic        err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  song_q, song_d;
    logic        lrst_q, lrst_d;
    logic        hold_q, hold_d;
    logic        playing_q, playing_d;
    logic        done_q, done_d;

    // Next-state, counter and registered-output decode.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        wd_d    = wd_q;
        hc_d    = hc_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (btn_start) begin
                    state_d = S_ARM;
                    err_d   = 1'b0;
                end else if (btn_sel) begin
                    sel_d = (sel_q == 2'd3) ? 2'd1 : sel_q + 2'd1;
                end
            end
            S_ARM: begin
                wd_d    = '0;
                state_d = S_PLAY;
            end
            S_PLAY: begin
                if (finish) begin
                    state_d = S_DONE;
                    hc_d    = '0;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else if (btn_stop) begin
                    state_d = S_ABORT;
                end else if (wd_q == TIMEOUT - 32'd1) begin
                    state_d = S_ABORT;
                    err_d   = 1'b1;
                end else begin
                    // Saturate rather than wrap if TIMEOUT is degenerate.
                    if (wd_q != '1) wd_d = wd_q + 32'd1;
                    if (btn_pause) state_d = S_PAUSE;
                end
            end
            S_PAUSE: begin
                if (finish) begin
                    state_d = S_DONE;
                    hc_d    = '0;
                    if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
                end else if (btn_stop) begin
                    state_d = S_ABORT;
                end else if (btn_pause) begin
                    state_d = S_PLAY;
                end
            end
            S_DONE: begin
                if (hc_q == DONE_HOLD - 32'd1) begin
                    state_d = S_IDLE;
                end else if (hc_q != '1) begin
                    hc_d = hc_q + 32'd1;
                end
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        song_d    = (state_d == S_PLAY || state_d == S_PAUSE) ? sel_d : 2'd0;
        lrst_d    = (state_d == S_ARM || state_d == S_ABORT);
        hold_d    = (state_d == S_PAUSE);
        playing_d = (state_d == S_PLAY || state_d == S_PAUSE);
        done_d    = (state_d == S_DONE);
    end

    // State, counters and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            sel_q     <= 2'd1;
            wd_q      <= '0;
            hc_q      <= '0;
            err_q     <= 1'b0;
            cnt_q     <= '0;
            song_q    <= 2'd0;
            lrst_q    <= 1'b0;
            hold_q    <= 1'b0;
            playing_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            wd_q      <= wd_d;
            hc_q      <= hc_d;
            err_q     <= err_d;
            cnt_q     <= cnt_d;
            song_q    <= song_d;
            lrst_q    <= lrst_d;
            hold_q    <= hold_d;
            playing_q <= playing_d;
            done_q    <= done_d;
        end
    end

    assign song       = song_q;
    assign sel_song   = sel_q;
    assign loader_rst = lrst_q;
    assign hold       = hold_q;
    assign playing    = playing_q;
    assign done       = done_q;
    assign error      = err_q;
    assign play_cnt   = cnt_q;

endmodule

// File: tb/tb_song_ctrl.sv
// Bench for song_ctrl: vector table, randomized run against a session-level
// reference model, and hand sequences for watchdog, saturation and reset.
module tb_song_ctrl;

    localparam int TO = 50;
    localparam int DH = 4;

    // Input pulse bit positions within a 5-bit stimulus word.
    localparam logic [4:0] I_SEL   = 5'b10000;
    localparam logic [4:0] I_START = 5'b01000;
    localparam logic [4:0] I_PAUSE = 5'b00100;
    localparam logic [4:0] I_STOP  = 5'b00010;
    localparam logic [4:0] I_FIN   = 5'b00001;
    localparam logic [4:0] I_NONE  = 5'b00000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_sel = 1'b0, btn_start = 1'b0, btn_pause = 1'b0, btn_stop = 1'b0, finish = 1'b0;
    logic [1:0] song, sel_song;
    logic       loader_rst, hold, playing, done, error;
    logic [7:0] play_cnt;

    int total = 0;
    int bad   = 0;

    song_ctrl #(.TIMEOUT(32'd50), .DONE_HOLD(32'd4)) dut (
        .clk(clk), .rst(rst),
        .btn_sel(btn_sel), .btn_start(btn_start), .btn_pause(btn_pause),
        .btn_stop(btn_stop), .finish(finish),
        .song(song), .sel_song(sel_song), .loader_rst(loader_rst),
        .hold(hold), .playing(playing), .done(done), .error(error),
        .play_cnt(play_cnt)
    );

    always #5 clk = ~clk;

    // Session-level reference: what phase the session is in, and how much of
    // each time budget has been consumed.
    typedef enum int { PH_IDLE, PH_ARM, PH_PLAY, PH_PAUSE, PH_DONE, PH_ABORT } phase_t;
    phase_t m_phase;
    int     m_sel, m_err, m_cnt, m_active, m_dleft;

    function automatic void model_reset();
        m_phase = PH_IDLE; m_sel = 1; m_err = 0; m_cnt = 0; m_active = 0; m_dleft = 0;
    endfunction

    function automatic void song_completed();
        m_phase = PH_DONE;
        m_dleft = DH;
        if (m_cnt < 255) m_cnt++;
    endfunction

    function automatic void model_step(input logic [4:0] in);
        case (m_phase)
            PH_IDLE:
                if (in[3]) begin m_phase = PH_ARM; m_err = 0; end
                else if (in[4]) m_sel = (m_sel % 3) + 1;
            PH_ARM: begin m_phase = PH_PLAY; m_active = 0; end
            PH_PLAY:
                if (in[0]) song_completed();
                else if (in[1]) m_phase = PH_ABORT;
                else begin
                    m_active++;
                    if (m_active == TO) begin m_phase = PH_ABORT; m_err = 1; end
                    else if (in[2]) m_phase = PH_PAUSE;
                end
            PH_PAUSE:
                if (in[0]) song_completed();
                else if (in[1]) m_phase = PH_ABORT;
                else if (in[2]) m_phase = PH_PLAY;
            PH_DONE: begin
                m_dleft--;
                if (m_dleft == 0) m_phase = PH_IDLE;
            end
            default: m_phase = PH_IDLE;
        endcase
    endfunction

    function automatic logic [16:0] mk(input int s, input int sg, input bit lr, input bit hd,
                                       input bit pl, input bit dn, input bit er, input int c);
        return {s[1:0], sg[1:0], lr, hd, pl, dn, er, c[7:0]};
    endfunction

    function automatic logic [16:0] model_vec();
        bit act;
        act = (m_phase == PH_PLAY) || (m_phase == PH_PAUSE);
        return mk(m_sel, act ? m_sel : 0, (m_phase == PH_ARM) || (m_phase == PH_ABORT),
                  m_phase == PH_PAUSE, act, m_phase == PH_DONE, m_err != 0, m_cnt);
    endfunction

    function automatic logic [16:0] dut_vec();
        return {sel_song, song, loader_rst, hold, playing, done, error, play_cnt};
    endfunction

    task automatic check(input string name, input logic [16:0] act, input logic [16:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got {sel,song,lrst,hold,play,done,err,cnt}=%h expected %h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock: drive pulses, let the edge happen, sample 1 time unit later.
    task automatic cycle(input logic [4:0] in);
        {btn_sel, btn_start, btn_pause, btn_stop, finish} = in;
        @(posedge clk);
        model_step(in);
        #1;
        {btn_sel, btn_start, btn_pause, btn_stop, finish} = I_NONE;
        check("model", dut_vec(), model_vec());
    endtask

    typedef struct { logic [4:0] in; logic [16:0] exp; string name; } vec_t;
    vec_t tbl[$];

    initial begin
        int r, n;
        model_reset();
        #12;
        check("reset", dut_vec(), mk(1, 0, 0, 0, 0, 0, 0, 0));
        rst = 1'b0;

        //              inputs           sel song lr hd pl dn er cnt
        tbl.push_back('{I_SEL,           mk(2, 0, 0, 0, 0, 0, 0, 0), "sel1"});
        tbl.push_back('{I_SEL,           mk(3, 0, 0, 0, 0, 0, 0, 0), "sel2"});
        tbl.push_back('{I_SEL,           mk(1, 0, 0, 0, 0, 0, 0, 0), "sel3_wrap"});
        tbl.push_back('{I_SEL,           mk(2, 0, 0, 0, 0, 0, 0, 0), "sel4"});
        tbl.push_back('{I_STOP,          mk(2, 0, 0, 0, 0, 0, 0, 0), "idle_stop"});
        tbl.push_back('{I_PAUSE,         mk(2, 0, 0, 0, 0, 0, 0, 0), "idle_pause"});
        tbl.push_back('{I_START,         mk(2, 0, 1, 0, 0, 0, 0, 0), "arm"});
        tbl.push_back('{I_NONE,          mk(2, 2, 0, 0, 1, 0, 0, 0), "play"});
        tbl.push_back('{I_PAUSE,         mk(2, 2, 0, 1, 1, 0, 0, 0), "pause"});
        tbl.push_back('{I_SEL,           mk(2, 2, 0, 1, 1, 0, 0, 0), "pause_sel"});
        tbl.push_back('{I_PAUSE,         mk(2, 2, 0, 0, 1, 0, 0, 0), "resume"});
        tbl.push_back('{I_FIN | I_STOP,  mk(2, 0, 0, 0, 0, 1, 0, 1), "fin_stop"});
        tbl.push_back('{I_START,         mk(2, 0, 0, 0, 0, 1, 0, 1), "done2"});
        tbl.push_back('{I_SEL,           mk(2, 0, 0, 0, 0, 1, 0, 1), "done3"});
        tbl.push_back('{I_NONE,          mk(2, 0, 0, 0, 0, 1, 0, 1), "done4"});
        tbl.push_back('{I_NONE,          mk(2, 0, 0, 0, 0, 0, 0, 1), "done_exit"});
        tbl.push_back('{I_START | I_SEL, mk(2, 0, 1, 0, 0, 0, 0, 1), "start_sel"});
        tbl.push_back('{I_NONE,          mk(2, 2, 0, 0, 1, 0, 0, 1), "play2"});
        tbl.push_back('{I_PAUSE,         mk(2, 2, 0, 1, 1, 0, 0, 1), "pause2"});
        tbl.push_back('{I_STOP,          mk(2, 0, 1, 0, 0, 0, 0, 1), "pause_stop"});
        tbl.push_back('{I_NONE,          mk(2, 0, 0, 0, 0, 0, 0, 1), "abort_exit"});
        tbl.push_back('{I_SEL,           mk(3, 0, 0, 0, 0, 0, 0, 1), "sel5"});
        foreach (tbl[i]) begin
            cycle(tbl[i].in);
            check(tbl[i].name, dut_vec(), tbl[i].exp);
        end

        // Randomized pulses against the reference model.
        for (int k = 0; k < 1500; k++) begin
            logic [4:0] in;
            in = I_NONE;
            r = $urandom_range(0, 99);
            if (r < 6)       in |= I_SEL;
            r = $urandom_range(0, 99);
            if (r < 5)       in |= I_START;
            r = $urandom_range(0, 99);
            if (r < 5)       in |= I_PAUSE;
            r = $urandom_range(0, 99);
            if (r < 2)       in |= I_STOP;
            r = $urandom_range(0, 99);
            if (r < 3)       in |= I_FIN;
            cycle(in);
        end

        // Drain to IDLE within a bounded number of cycles.
        n = 0;
        while (m_phase != PH_IDLE && n < 200) begin
            cycle(I_STOP);
            n++;
        end
        check_bit("drain_to_idle", playing | done | loader_rst, 1'b0);

        // Watchdog freezes while paused: 30 active, 100 paused, 20 active.
        cycle(I_START);
        cycle(I_NONE);
        for (int k = 0; k < 29; k++) cycle(I_NONE);
        cycle(I_PAUSE);
        check_bit("paused_hold", hold, 1'b1);
        for (int k = 0; k < 99; k++) cycle(I_NONE);
        cycle(I_PAUSE);
        check_bit("pause_no_err", error, 1'b0);
        for (int k = 0; k < 19; k++) cycle(I_NONE);
        check_bit("wd_19_playing", playing, 1'b1);
        check_bit("wd_19_no_err", error, 1'b0);
        cycle(I_NONE);
        check_bit("timeout_err", error, 1'b1);
        check_bit("timeout_lrst", loader_rst, 1'b1);
        check_bit("timeout_song0", song == 2'd0, 1'b1);
        cycle(I_NONE);
        check_bit("err_sticky", error, 1'b1);
        cycle(I_START);
        check_bit("start_clears_err", error, 1'b0);
        cycle(I_NONE);
        cycle(I_STOP);
        cycle(I_NONE);

        // Counter saturation over 256 completed songs.
        for (int s = 0; s < 256; s++) begin
            cycle(I_START);
            cycle(I_NONE);
            cycle(I_FIN);
            for (int k = 0; k < DH; k++) cycle(I_NONE);
        end
        check_bit("cnt_saturated", play_cnt == 8'd255, 1'b1);

        // Asynchronous reset mid-PLAY, between clock edges.
        cycle(I_SEL);
        cycle(I_START);
        cycle(I_NONE);
        check_bit("pre_rst_playing", playing, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("async_rst", dut_vec(), mk(1, 0, 0, 0, 0, 0, 0, 0));
        #3;
        rst = 1'b0;
        cycle(I_SEL);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #400000;
        $display("FAIL timeout_guard: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

endmodule
